vga_timing_decoder: RTL
=======================

# vga_timing_decoder

Receive-side counterpart of the VGA timing/draw pipeline: consumes a pixel-clock-synchronous hs/vs/rgb stream, recovers horizontal and vertical pixel position, measures line and frame lengths, and declares lock once timing matches the configured raster. Sits at the display-output boundary as an in-system checker and as the position source for any frame-capture or overlay block fed from a VGA stream.

## Interface
- H_TOTAL, 1056: expected clocks per line (1..2047)
- V_TOTAL, 628: expected lines per frame (1..1023)
- SYNC_POL, 1: active level of hs_in/vs_in (1 = active-high)
- LOCK_FRAMES, 2: consecutive good frames required for lock (1..15)

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- rgb_in  in  12  {r,g,b}, 4 bits each
- hcount_out  out  11  clocks since last hs leading edge
- vcount_out  out  10  hs leading edges since last vs leading edge
- rgb_out  out  12  rgb_in delayed to align with counts
- frame_start  out  1  one-cycle pulse on vs leading edge
- locked  out  1  timing matches H_TOTAL/V_TOTAL
- line_len  out  11  last measured line length
- frame_len  out  10  last measured frame length
- hs_err  out  1  one-cycle pulse, bad line while locked
- vs_err  out  1  one-cycle pulse, bad frame while locked
- err_count  out  16  saturating error count (see Configuration)

## Operation
- Stage 1 registers hs_in, vs_in, rgb_in; leading edge = stage-1 value becomes SYNC_POL while previous was not.
- hcount: leading hs edge -> 0; else +1, saturating at 2047 (sets line_bad).
- On hs edge: line_len <= hcount+1; line bad if != H_TOTAL. First hs edge after reset/SEARCH entry does not measure (hs_seen flag).
- vcount: vs edge -> 0; else on hs edge +1, saturating at 1023.
- On vs edge: frame_len <= vcount+1; frame good iff frame_len == V_TOTAL and no bad line since previous vs edge.
- Simultaneous hs and vs edge: both counters -> 0, both captures taken, line checked, then frame evaluated including that line.
- FSM:
  - SEARCH: locked=0; first vs edge -> ACQUIRE, good_cnt=0, clear line_bad history.
  - ACQUIRE: each vs edge: good -> good_cnt+1, reaching LOCK_FRAMES -> LOCKED; bad -> good_cnt=0.
  - LOCKED: bad line -> hs_err pulse, -> SEARCH; bad frame -> vs_err pulse, -> SEARCH. Both same cycle: both pulses.
- No errors reported outside LOCKED.

## Timing
- All outputs registered; hcount_out/vcount_out/rgb_out/frame_start lag inputs by 2 clocks.
- locked rises the cycle after the qualifying vs edge is registered (3 clocks after vs_in edge); falls same cycle as hs_err/vs_err.
- Reset (async assert, sync deassert assumed upstream): all outputs 0, FSM SEARCH, hs_seen 0, good_cnt 0.
- Reset mid-frame: first post-reset line and frame are unmeasured; lock needs LOCK_FRAMES full frames after the first vs edge.

## Configuration
- VGA_DECODER_STATS_EN defined: err_count increments on each hs_err or vs_err cycle (by 1 even if both), saturates at 65535, reset to 0.
- Undefined: counter logic omitted, err_count tied to 0.

## Structure
- vga_pkg: default H_TOTAL/V_TOTAL for 800x600@60, counter widths, FSM state typedef.
- Sub-module vga_sync_edge: stage-1 register plus leading-edge detect for one sync line (instantiated for hs and vs).

## Test plan
- Clean 1056x628 raster, SYNC_POL=1, LOCK_FRAMES=2 -> locked=1 after 2nd full frame following first vs edge; line_len=1056, frame_len=628; no error pulses.
- Locked, one line shortened to 1055 clocks -> hs_err single pulse, line_len=1055, locked=0, relock after 2 good frames.
- Locked, frame of 627 lines -> vs_err pulse, frame_len=627, locked drops.
- hs and vs edges in same cycle -> hcount_out=0, vcount_out=0 two clocks later, frame_start=1.
- hs held inactive 3000 clocks -> hcount_out saturates at 2047, next edge reports line_len=2047 and error if locked.
- rst_n pulsed low mid-frame while locked -> all outputs 0 immediately; with STATS_EN, err_count=0 and counts 1 per subsequent injected error.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, counter widths and FSM state encoding for the VGA timing decoder.
package vga_pkg;

    localparam int H_TOTAL_DEF = 1056;  // 800x600@60 clocks per line
    localparam int V_TOTAL_DEF = 628;   // 800x600@60 lines per frame

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int GOOD_W = 4;
    localparam int ERR_W  = 16;

    typedef logic [1:0] state_t;
    localparam state_t ST_SEARCH  = 2'd0;
    localparam state_t ST_ACQUIRE = 2'd1;
    localparam state_t ST_LOCKED  = 2'd2;

    function automatic logic [HCNT_W-1:0] h_sat_inc(input logic [HCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [VCNT_W-1:0] v_sat_inc(input logic [VCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Stage-1 register and leading-edge detector for one sync line.
module vga_sync_edge #(
    parameter logic SYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic lead_edge
);

    logic sync_q;
    logic sync_d;

    // Reset to the active level so a sync held active through reset is not seen as an edge.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= SYNC_POL;
            sync_d <= SYNC_POL;
        end else begin
            sync_q <= sync_in;
            sync_d <= sync_q;
        end
    end

    assign lead_edge = (sync_q == SYNC_POL) && (sync_d != SYNC_POL);

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers raster position from an hs/vs/rgb stream and tracks lock to the configured timing.
// Optional error statistics counter enabled by defining VGA_DECODER_STATS_EN.
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int   H_TOTAL     = H_TOTAL_DEF,
    parameter int   V_TOTAL     = V_TOTAL_DEF,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [11:0]       rgb_in,
    output logic [HCNT_W-1:0] hcount_out,
    output logic [VCNT_W-1:0] vcount_out,
    output logic [11:0]       rgb_out,
    output logic              frame_start,
    output logic              locked,
    output logic [HCNT_W-1:0] line_len,
    output logic [VCNT_W-1:0] frame_len,
    output logic              hs_err,
    output logic              vs_err,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [HCNT_W-1:0] H_EXP  = HCNT_W'(H_TOTAL);
    localparam logic [VCNT_W-1:0] V_EXP  = VCNT_W'(V_TOTAL);
    localparam logic [GOOD_W-1:0] G_LOCK = GOOD_W'(LOCK_FRAMES);

    logic              hs_edge;
    logic              vs_edge;
    logic [11:0]       rgb_s1;
    logic              hs_seen;
    logic              bad_hist;
    state_t            state;
    state_t            state_nxt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nxt;
    logic              hs_err_nxt;
    logic              vs_err_nxt;

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_in   (hs_in),
        .lead_edge (hs_edge)
    );

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_in   (vs_in),
        .lead_edge (vs_edge)
    );

    // A saturated counter marks the line/frame bad even if the clamped length happens to match.
    logic [HCNT_W-1:0] line_len_now;
    logic [VCNT_W-1:0] frame_len_now;
    logic              line_measured;
    logic              line_bad_now;
    logic              frame_good;
    logic              enter_search;

    assign line_len_now  = h_sat_inc(hcount_out);
    assign frame_len_now = v_sat_inc(vcount_out);
    assign line_measured = hs_edge && hs_seen;
    assign line_bad_now  = line_measured && ((hcount_out == '1) || (line_len_now != H_EXP));
    assign frame_good    = (vcount_out != '1) && (frame_len_now == V_EXP)
                           && !bad_hist && !line_bad_now;
    assign enter_search  = (state == ST_LOCKED) && (state_nxt == ST_SEARCH);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        good_nxt   = good_cnt;
        hs_err_nxt = 1'b0;
        vs_err_nxt = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_nxt = ST_ACQUIRE;
                    good_nxt  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (vs_edge) begin
                    if (frame_good) begin
                        good_nxt = good_cnt + 1'b1;
                        if (good_nxt == G_LOCK) state_nxt = ST_LOCKED;
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                hs_err_nxt = line_bad_now;
                vs_err_nxt = vs_edge && !frame_good;
                if (hs_err_nxt || vs_err_nxt) state_nxt = ST_SEARCH;
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
            hs_seen  <= 1'b0;
            bad_hist <= 1'b0;
            rgb_s1   <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            rgb_s1   <= rgb_in;
            if (enter_search)  hs_seen <= 1'b0;
            else if (hs_edge)  hs_seen <= 1'b1;
            // The line closed by a coincident hs edge belongs to the frame ending now.
            if (vs_edge)           bad_hist <= 1'b0;
            else if (line_bad_now) bad_hist <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out  <= '0;
            vcount_out  <= '0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            line_len    <= '0;
            frame_len   <= '0;
            hs_err      <= 1'b0;
            vs_err      <= 1'b0;
        end else begin
            hcount_out  <= hs_edge ? '0 : h_sat_inc(hcount_out);
            if (vs_edge)      vcount_out <= '0;
            else if (hs_edge) vcount_out <= v_sat_inc(vcount_out);
            rgb_out     <= rgb_s1;
            frame_start <= vs_edge;
            // Rises one cycle after entering LOCKED, falls together with the error pulse.
            locked      <= (state == ST_LOCKED) && (state_nxt == ST_LOCKED);
            if (line_measured) line_len <= line_len_now;
            if (vs_edge)       frame_len <= frame_len_now;
            hs_err      <= hs_err_nxt;
            vs_err      <= vs_err_nxt;
        end
    end

`ifdef VGA_DECODER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if ((hs_err || vs_err) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule
